// File: rtl/databus_rr_arbiter_pkg.sv
// Shared databus definitions: default field widths, arbiter state encoding and the
// packed-port slice helpers used by every databus-facing unit.
package databus_rr_arbiter_pkg;

  localparam int DB_ADDR_W = 32;
  localparam int DB_DATA_W = 32;
  localparam int DB_LEN_W  = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Width of an index into NUM_REQ requesters; never narrower than one bit.
  function automatic int ptr_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // LSB position of requester idx inside a packed per-requester bus of field width w.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: one-hot of the first request found scanning upward from ptr_i
// with wrap at NUM_REQ-1, plus the index of that pick and a valid flag.
module rr_priority_picker #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [PTR_W-1:0]   pick_idx_o,
  output logic               pick_valid_o
);

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    int  idx;
    logic found;
    idx          = 0;
    found        = 1'b0;
    pick_o       = '0;
    pick_idx_o   = '0;
    pick_valid_o = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_i[idx]) begin
        found       = 1'b1;
        pick_o[idx] = 1'b1;
        pick_idx_o  = PTR_W'(idx);
      end
    end
    pick_valid_o = found;
  end

endmodule

// File: rtl/databus_rr_arbiter.sv
// Burst-locked round-robin arbiter sharing one databus master port between NUM_REQ
// requester ports; the grant is held until the granted requester's last beat completes.
module databus_rr_arbiter
  import databus_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int AXI_ADDR_W = DB_ADDR_W,
  parameter int AXI_DATA_W = DB_DATA_W,
  parameter int LEN_W      = DB_LEN_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ*AXI_ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*AXI_DATA_W-1:0]   req_wdata_i,
  input  logic [NUM_REQ*AXI_DATA_W/8-1:0] req_wstrb_i,
  input  logic [NUM_REQ*LEN_W-1:0]        req_len_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic [NUM_REQ-1:0]              req_last_o,
  output logic [AXI_DATA_W-1:0]           req_rdata_o,
  output logic                            m_valid_o,
  output logic [AXI_ADDR_W-1:0]           m_addr_o,
  output logic [AXI_DATA_W-1:0]           m_wdata_o,
  output logic [AXI_DATA_W/8-1:0]         m_wstrb_o,
  output logic [LEN_W-1:0]                m_len_o,
  input  logic                            m_ready_i,
  input  logic [AXI_DATA_W-1:0]           m_rdata_i,
  input  logic                            m_last_i,
  output logic [NUM_REQ-1:0]              grant_o,
  output logic                            busy_o
);

  localparam int PTR_W  = ptr_width(NUM_REQ);
  localparam int STRB_W = AXI_DATA_W / 8;

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;

  logic [NUM_REQ-1:0] pick;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               burst_done;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req_i        (req_valid_i),
    .ptr_i        (ptr_q),
    .pick_o       (pick),
    .pick_idx_o   (pick_idx),
    .pick_valid_o (pick_valid)
  );

  // One-hot AND-OR select; with grant_q all zero every master field collapses to 0.
  always_comb begin
    m_valid_o = 1'b0;
    m_addr_o  = '0;
    m_wdata_o = '0;
    m_wstrb_o = '0;
    m_len_o   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        m_valid_o = m_valid_o | req_valid_i[i];
        m_addr_o  = m_addr_o  | req_addr_i[slice_lo(i, AXI_ADDR_W) +: AXI_ADDR_W];
        m_wdata_o = m_wdata_o | req_wdata_i[slice_lo(i, AXI_DATA_W) +: AXI_DATA_W];
        m_wstrb_o = m_wstrb_o | req_wstrb_i[slice_lo(i, STRB_W) +: STRB_W];
        m_len_o   = m_len_o   | req_len_i[slice_lo(i, LEN_W) +: LEN_W];
      end
    end
  end

  assign req_ready_o = grant_q & {NUM_REQ{m_ready_i}};
  assign req_last_o  = grant_q & {NUM_REQ{m_last_i}};
  assign req_rdata_o = m_rdata_i;
  assign burst_done  = m_valid_o & m_ready_i & m_last_i;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q == ST_LOCKED);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick;
          gidx_d  = pick_idx;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        // Only the last beat releases the lock; a dropped valid just stalls the burst.
        if (burst_done) begin
          grant_d = '0;
          ptr_d   = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      gidx_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
    end
  end

endmodule

// File: tb/tb_databus_rr_arbiter.sv
// Directed bench for databus_rr_arbiter: a 2-port instance for the handshake scenarios
// and a 3-port instance for round-robin fairness.
module tb_databus_rr_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [1:0]      r2_valid;
  logic [2*AW-1:0] r2_addr;
  logic [2*DW-1:0] r2_wdata;
  logic [2*SW-1:0] r2_wstrb;
  logic [2*LW-1:0] r2_len;
  logic [1:0]      r2_ready, r2_last;
  logic [DW-1:0]   r2_rdata;
  logic            m2_valid, m2_ready, m2_last;
  logic [AW-1:0]   m2_addr;
  logic [DW-1:0]   m2_wdata, m2_rdata;
  logic [SW-1:0]   m2_wstrb;
  logic [LW-1:0]   m2_len;
  logic [1:0]      g2;
  logic            busy2;

  logic [2:0]      r3_valid;
  logic [3*AW-1:0] r3_addr;
  logic [3*DW-1:0] r3_wdata;
  logic [3*SW-1:0] r3_wstrb;
  logic [3*LW-1:0] r3_len;
  logic [2:0]      r3_ready, r3_last;
  logic [DW-1:0]   r3_rdata;
  logic            m3_valid, m3_ready, m3_last;
  logic [AW-1:0]   m3_addr;
  logic [DW-1:0]   m3_wdata, m3_rdata;
  logic [SW-1:0]   m3_wstrb;
  logic [LW-1:0]   m3_len;
  logic [2:0]      g3;
  logic            busy3;

  databus_rr_arbiter #(.NUM_REQ(2), .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .LEN_W(LW)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid_i(r2_valid), .req_addr_i(r2_addr), .req_wdata_i(r2_wdata),
    .req_wstrb_i(r2_wstrb), .req_len_i(r2_len),
    .req_ready_o(r2_ready), .req_last_o(r2_last), .req_rdata_o(r2_rdata),
    .m_valid_o(m2_valid), .m_addr_o(m2_addr), .m_wdata_o(m2_wdata),
    .m_wstrb_o(m2_wstrb), .m_len_o(m2_len),
    .m_ready_i(m2_ready), .m_rdata_i(m2_rdata), .m_last_i(m2_last),
    .grant_o(g2), .busy_o(busy2)
  );

  databus_rr_arbiter #(.NUM_REQ(3), .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .LEN_W(LW)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid_i(r3_valid), .req_addr_i(r3_addr), .req_wdata_i(r3_wdata),
    .req_wstrb_i(r3_wstrb), .req_len_i(r3_len),
    .req_ready_o(r3_ready), .req_last_o(r3_last), .req_rdata_o(r3_rdata),
    .m_valid_o(m3_valid), .m_addr_o(m3_addr), .m_wdata_o(m3_wdata),
    .m_wstrb_o(m3_wstrb), .m_len_o(m3_len),
    .m_ready_i(m3_ready), .m_rdata_i(m3_rdata), .m_last_i(m3_last),
    .grant_o(g3), .busy_o(busy3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    r2_valid = 2'b11;
    r2_addr  = {32'h0000_1100, 32'h0000_1000};
    r2_len   = '0;
    m2_ready = 1'b1;
    m2_last  = 1'b1;
    m2_rdata = 32'hA5A5_0001;
    m3_rdata = 32'h5A5A_0003;
    step();
    step();
    n_total++; if (g2 !== 2'b00) $display("FAIL reset_grant: got %b want 00", g2); else n_pass++;
    n_total++; if (busy2 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy2); else n_pass++;
    n_total++; if (m2_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", m2_valid); else n_pass++;
    n_total++; if (r2_ready !== 2'b00) $display("FAIL reset_ready: got %b want 00", r2_ready); else n_pass++;
    n_total++; if (r2_last !== 2'b00) $display("FAIL reset_last: got %b want 00", r2_last); else n_pass++;
    n_total++; if (m2_addr !== 32'h0) $display("FAIL reset_m_addr: got %h want 0", m2_addr); else n_pass++;
    n_total++; if (r2_rdata !== 32'hA5A5_0001) $display("FAIL reset_rdata: got %h want a5a50001", r2_rdata); else n_pass++;
    n_total++; if (r3_rdata !== 32'h5A5A_0003) $display("FAIL reset_rdata3: got %h want 5a5a0003", r3_rdata); else n_pass++;
    n_total++; if (g3 !== 3'b000) $display("FAIL reset_grant3: got %b want 000", g3); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_contention();
    step();
    n_total++; if (g2 !== 2'b01) $display("FAIL cont_first_grant: got %b want 01", g2); else n_pass++;
    n_total++; if (m2_addr !== 32'h1000) $display("FAIL cont_first_addr: got %h want 1000", m2_addr); else n_pass++;
    n_total++; if (r2_ready !== 2'b01) $display("FAIL cont_first_ready: got %b want 01", r2_ready); else n_pass++;
    n_total++; if (r2_last !== 2'b01) $display("FAIL cont_first_last: got %b want 01", r2_last); else n_pass++;
    n_total++; if (busy2 !== 1'b1) $display("FAIL cont_busy: got %b want 1", busy2); else n_pass++;
    step();
    n_total++; if (g2 !== 2'b00) $display("FAIL cont_bubble_grant: got %b want 00", g2); else n_pass++;
    n_total++; if (m2_valid !== 1'b0) $display("FAIL cont_bubble_valid: got %b want 0", m2_valid); else n_pass++;
    n_total++; if (busy2 !== 1'b0) $display("FAIL cont_bubble_busy: got %b want 0", busy2); else n_pass++;
    r2_valid = 2'b10;
    step();
    n_total++; if (g2 !== 2'b10) $display("FAIL cont_second_grant: got %b want 10", g2); else n_pass++;
    n_total++; if (m2_addr !== 32'h1100) $display("FAIL cont_second_addr: got %h want 1100", m2_addr); else n_pass++;
    n_total++; if (r2_ready !== 2'b10) $display("FAIL cont_second_ready: got %b want 10", r2_ready); else n_pass++;
    step();
    n_total++; if (g2 !== 2'b00) $display("FAIL cont_second_release: got %b want 00", g2); else n_pass++;
    r2_valid = 2'b11;
    step();
    n_total++; if (g2 !== 2'b01) $display("FAIL cont_ptr_wrapped: got %b want 01", g2); else n_pass++;
    step();
    n_total++; if (g2 !== 2'b00) $display("FAIL cont_third_release: got %b want 00", g2); else n_pass++;
    r2_valid = 2'b00;
    m2_ready = 1'b0;
    m2_last  = 1'b0;
  endtask

  task automatic test_single();
    r2_addr[0 +: AW] = 32'h1000_0040;
    r2_len[0 +: LW]  = 8'd3;
    r2_valid = 2'b01;
    #1;
    n_total++; if (m2_valid !== 1'b0) $display("FAIL single_latency: got %b want 0", m2_valid); else n_pass++;
    step();
    n_total++; if (g2 !== 2'b01) $display("FAIL single_grant: got %b want 01", g2); else n_pass++;
    n_total++; if (m2_len !== 8'd3) $display("FAIL single_len: got %0d want 3", m2_len); else n_pass++;
    n_total++; if (m2_addr !== 32'h1000_0040) $display("FAIL single_addr: got %h want 10000040", m2_addr); else n_pass++;
    m2_ready = 1'b1;
    for (int beat = 1; beat <= 4; beat++) begin
      m2_last = (beat == 4);
      #1;
      n_total++; if (r2_ready !== 2'b01) $display("FAIL single_ready beat %0d: got %b want 01", beat, r2_ready); else n_pass++;
      n_total++; if (r2_last !== ((beat == 4) ? 2'b01 : 2'b00))
        $display("FAIL single_last beat %0d: got %b want %b", beat, r2_last, (beat == 4) ? 2'b01 : 2'b00);
      else n_pass++;
      step();
      n_total++; if (g2 !== ((beat == 4) ? 2'b00 : 2'b01))
        $display("FAIL single_hold beat %0d: got %b want %b", beat, g2, (beat == 4) ? 2'b00 : 2'b01);
      else n_pass++;
    end
    r2_valid = 2'b00;
    m2_ready = 1'b0;
    m2_last  = 1'b0;
  endtask

  task automatic test_lock();
    bit [3:0] rdy = 4'b1101;
    bit [3:0] lst = 4'b1000;
    r2_addr  = {32'h0000_3000, 32'h0000_2000};
    r2_len   = {8'd5, 8'd2};
    r2_valid = 2'b01;
    step();
    n_total++; if (g2 !== 2'b01) $display("FAIL lock_grant0: got %b want 01", g2); else n_pass++;
    r2_valid = 2'b11;
    for (int c = 0; c < 4; c++) begin
      m2_ready = rdy[c];
      m2_last  = lst[c];
      #1;
      n_total++; if (r2_ready !== {1'b0, rdy[c]}) $display("FAIL lock_ready cyc %0d: got %b want %b", c, r2_ready, {1'b0, rdy[c]}); else n_pass++;
      n_total++; if (m2_addr !== 32'h2000) $display("FAIL lock_addr cyc %0d: got %h want 2000", c, m2_addr); else n_pass++;
      n_total++; if (m2_len !== 8'd2) $display("FAIL lock_len cyc %0d: got %0d want 2", c, m2_len); else n_pass++;
      step();
      n_total++; if (g2 !== ((c == 3) ? 2'b00 : 2'b01))
        $display("FAIL lock_hold cyc %0d: got %b want %b", c, g2, (c == 3) ? 2'b00 : 2'b01);
      else n_pass++;
    end
    step();
    n_total++; if (g2 !== 2'b10) $display("FAIL lock_grant1: got %b want 10", g2); else n_pass++;
    n_total++; if (m2_addr !== 32'h3000) $display("FAIL lock_addr1: got %h want 3000", m2_addr); else n_pass++;
    n_total++; if (m2_len !== 8'd5) $display("FAIL lock_len1: got %0d want 5", m2_len); else n_pass++;
    n_total++; if (r2_ready !== 2'b10) $display("FAIL lock_ready1: got %b want 10", r2_ready); else n_pass++;
    step();
    n_total++; if (g2 !== 2'b00) $display("FAIL lock_release1: got %b want 00", g2); else n_pass++;
    r2_valid = 2'b00;
    m2_ready = 1'b0;
    m2_last  = 1'b0;
  endtask

  task automatic test_dropout();
    r2_addr  = {32'h0000_4400, 32'h0000_4000};
    r2_len   = {8'd7, 8'd3};
    r2_wdata = {32'h1111_2222, 32'hDEAD_BEEF};
    r2_wstrb = {4'h3, 4'hF};
    r2_valid = 2'b01;
    step();
    n_total++; if (g2 !== 2'b01) $display("FAIL drop_grant: got %b want 01", g2); else n_pass++;
    n_total++; if (m2_wdata !== 32'hDEAD_BEEF) $display("FAIL drop_wdata: got %h want deadbeef", m2_wdata); else n_pass++;
    n_total++; if (m2_wstrb !== 4'hF) $display("FAIL drop_wstrb: got %h want f", m2_wstrb); else n_pass++;
    m2_ready = 1'b1;
    m2_last  = 1'b0;
    step();
    r2_valid = 2'b00;
    for (int d = 0; d < 2; d++) begin
      #1;
      n_total++; if (m2_valid !== 1'b0) $display("FAIL drop_m_valid cyc %0d: got %b want 0", d, m2_valid); else n_pass++;
      step();
      n_total++; if (g2 !== 2'b01) $display("FAIL drop_hold cyc %0d: got %b want 01", d, g2); else n_pass++;
      n_total++; if (busy2 !== 1'b1) $display("FAIL drop_busy cyc %0d: got %b want 1", d, busy2); else n_pass++;
    end
    r2_valid = 2'b01;
    for (int b = 2; b <= 4; b++) begin
      m2_last = (b == 4);
      #1;
      n_total++; if (m2_valid !== 1'b1) $display("FAIL drop_resume beat %0d: got %b want 1", b, m2_valid); else n_pass++;
      step();
    end
    n_total++; if (g2 !== 2'b00) $display("FAIL drop_release: got %b want 00", g2); else n_pass++;
    r2_valid = 2'b00;
    r2_wstrb = '0;
    m2_ready = 1'b0;
    m2_last  = 1'b0;
  endtask

  task automatic test_fairness();
    logic [2:0]    exp_g;
    logic [AW-1:0] exp_addr;
    for (int i = 0; i < 3; i++) begin
      r3_addr[i*AW +: AW]  = 32'h5000 + 32'(i) * 32'h100;
      r3_wdata[i*DW +: DW] = 32'hC0DE_0000 + 32'(i);
      r3_len[i*LW +: LW]   = LW'(i);
    end
    r3_wstrb = '0;
    r3_valid = 3'b111;
    m3_ready = 1'b1;
    m3_last  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_g    = 3'b001 << (k % 3);
      exp_addr = 32'h5000 + 32'(k % 3) * 32'h100;
      step();
      n_total++; if (g3 !== exp_g) $display("FAIL fair_grant #%0d: got %b want %b", k, g3, exp_g); else n_pass++;
      n_total++; if (m3_addr !== exp_addr) $display("FAIL fair_addr #%0d: got %h want %h", k, m3_addr, exp_addr); else n_pass++;
      n_total++; if (m3_wdata !== 32'hC0DE_0000 + 32'(k % 3)) $display("FAIL fair_wdata #%0d: got %h", k, m3_wdata); else n_pass++;
      n_total++; if (m3_len !== LW'(k % 3)) $display("FAIL fair_len #%0d: got %0d want %0d", k, m3_len, k % 3); else n_pass++;
      n_total++; if (r3_ready !== exp_g) $display("FAIL fair_ready #%0d: got %b want %b", k, r3_ready, exp_g); else n_pass++;
      n_total++; if (r3_last !== exp_g) $display("FAIL fair_last #%0d: got %b want %b", k, r3_last, exp_g); else n_pass++;
      n_total++; if (m3_valid !== 1'b1 || busy3 !== 1'b1 || m3_wstrb !== 4'h0)
        $display("FAIL fair_valid_busy #%0d: got %b/%b/%h want 1/1/0", k, m3_valid, busy3, m3_wstrb);
      else n_pass++;
      step();
      n_total++; if (g3 !== 3'b000) $display("FAIL fair_bubble #%0d: got %b want 000", k, g3); else n_pass++;
    end
    r3_valid = 3'b000;
    m3_ready = 1'b0;
    m3_last  = 1'b0;
  endtask

  task automatic test_async_reset();
    r2_addr  = {32'h0000_6600, 32'h0000_6000};
    r2_len   = {8'd1, 8'd3};
    r2_valid = 2'b01;
    step();
    n_total++; if (g2 !== 2'b01) $display("FAIL arst_pre_grant: got %b want 01", g2); else n_pass++;
    m2_ready = 1'b1;
    m2_last  = 1'b0;
    step();
    #1;
    rst = 1'b1;
    #1;
    n_total++; if (g2 !== 2'b00) $display("FAIL arst_grant: got %b want 00", g2); else n_pass++;
    n_total++; if (m2_valid !== 1'b0) $display("FAIL arst_m_valid: got %b want 0", m2_valid); else n_pass++;
    n_total++; if (busy2 !== 1'b0) $display("FAIL arst_busy: got %b want 0", busy2); else n_pass++;
    n_total++; if (r2_ready !== 2'b00) $display("FAIL arst_ready: got %b want 00", r2_ready); else n_pass++;
    r2_valid = 2'b11;
    m2_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    n_total++; if (g2 !== 2'b01) $display("FAIL arst_rearb_ptr0: got %b want 01", g2); else n_pass++;
    n_total++; if (m2_addr !== 32'h6000) $display("FAIL arst_rearb_addr: got %h want 6000", m2_addr); else n_pass++;
    m2_ready = 1'b1;
    m2_last  = 1'b1;
    step();
    n_total++; if (g2 !== 2'b00) $display("FAIL arst_final_release: got %b want 00", g2); else n_pass++;
    r2_valid = 2'b00;
    m2_ready = 1'b0;
    m2_last  = 1'b0;
  endtask

  initial begin
    r2_valid = '0; r2_addr = '0; r2_wdata = '0; r2_wstrb = '0; r2_len = '0;
    m2_ready = 1'b0; m2_last = 1'b0; m2_rdata = '0;
    r3_valid = '0; r3_addr = '0; r3_wdata = '0; r3_wstrb = '0; r3_len = '0;
    m3_ready = 1'b0; m3_last = 1'b0; m3_rdata = '0;
    test_reset();
    test_contention();
    test_single();
    test_lock();
    test_dropout();
    test_fairness();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
